// File: rtl/sram_rd_burst_fetch.sv
// Burst read fetcher: turns one {addr, len} command into a stream of
// single-word reads on an arbiter read port, and buffers the returned words
// in a first-word-fall-through FIFO. Reads are only requested when the FIFO
// is guaranteed to have room for every word already in flight, so the
// consumer can stall indefinitely without losing data.
module sram_rd_burst_fetch #(
  parameter int SRAM_ADDR_WIDTH = 19,
  parameter int SRAM_DATA_WIDTH = 36,
  parameter int LEN_WIDTH       = 8,
  parameter int FIFO_AW         = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       cmd_valid,
  input  logic [SRAM_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]       cmd_len,
  output logic                       cmd_ready,
  output logic                       rd_req,
  output logic [SRAM_ADDR_WIDTH-1:0] rd_addr,
  input  logic                       rd_ack,
  input  logic                       rd_vld,
  input  logic [SRAM_DATA_WIDTH-1:0] rd_data,
  output logic                       out_vld,
  output logic [SRAM_DATA_WIDTH-1:0] out_data,
  output logic                       out_eop,
  input  logic                       out_rdy,
  output logic                       busy
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int PW    = FIFO_AW + 1;
  localparam int FW    = SRAM_DATA_WIDTH + 1;
  // Wide enough to sum occupancy, inflight and the two single-bit terms
  // without overflow.
  localparam int CW    = ((LEN_WIDTH > FIFO_AW) ? LEN_WIDTH : FIFO_AW) + 3;
  // Returns for reads issued before a reset can still arrive this long after
  // reset_n rises; they belong to a discarded burst.
  localparam logic [3:0] HOLD_CYCLES = 4'd8;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e                       state_q, state_d;
  logic [SRAM_ADDR_WIDTH-1:0]   base_q;
  logic [LEN_WIDTH-1:0]         len_q;
  logic [LEN_WIDTH:0]           acked_q, returned_q;
  logic [PW-1:0]                wr_ptr_q, rd_ptr_q;
  logic [FW-1:0]                mem_q [DEPTH];
  logic [3:0]                   hold_q;

  logic                         cmd_fire, ack_take, push, pop, empty, full;
  logic                         push_eop;
  logic [PW-1:0]                occ;
  logic [LEN_WIDTH:0]           inflight, len_ext;
  logic [CW-1:0]                issued_c, len_c, credit_c;
  logic [FW-1:0]                head;

  assign cmd_fire = cmd_valid & cmd_ready;
  assign ack_take = rd_ack & (state_q == ISSUE);
  assign push     = rd_vld & (hold_q == '0);
  assign pop      = out_vld & out_rdy;

  assign occ      = wr_ptr_q - rd_ptr_q;
  assign empty    = (occ == '0);
  assign full     = (occ == PW'(DEPTH));

  assign len_ext  = {1'b0, len_q};
  assign inflight = acked_q - returned_q;
  assign push_eop = (returned_q == (len_ext - (LEN_WIDTH + 1)'(1)));

  // Words already claimed (acked, including this cycle's ack) vs. burst length,
  // and FIFO slots claimed if one more read were requested now.
  assign issued_c = CW'(acked_q) + CW'(rd_ack);
  assign len_c    = CW'(len_q);
  assign credit_c = CW'(occ) + CW'(inflight) + CW'(rd_ack) + CW'(1);

  // The arbiter consumes the address shown in the previous cycle, so on an ack
  // the next unconsumed address must already be on the bus.
  assign rd_addr  = base_q + SRAM_ADDR_WIDTH'(acked_q) + SRAM_ADDR_WIDTH'(rd_ack);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: a zero-length command is accepted but never leaves IDLE.
  always_comb begin
    // NOTE: default first, so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_fire && (cmd_len != '0)) state_d = ISSUE;
      ISSUE:   if (acked_q == len_ext)          state_d = DRAIN;
      DRAIN:   if (returned_q == len_ext)       state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: requests only while words remain and FIFO credit allows.
  always_comb begin
    cmd_ready = 1'b0;
    rd_req    = 1'b0;
    case (state_q)
      IDLE:    cmd_ready = 1'b1;
      ISSUE:   rd_req    = (issued_c < len_c) && (credit_c <= CW'(DEPTH));
      default: ;
    endcase
  end

  // Command latch and the acked/returned burst counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q     <= '0;
      len_q      <= '0;
      acked_q    <= '0;
      returned_q <= '0;
    end else if (cmd_fire) begin
      base_q     <= cmd_addr;
      len_q      <= cmd_len;
      acked_q    <= '0;
      returned_q <= '0;
    end else begin
      if (ack_take) acked_q    <= acked_q + (LEN_WIDTH + 1)'(1);
      if (push)     returned_q <= returned_q + (LEN_WIDTH + 1)'(1);
    end
  end

  // Post-reset window during which stale returns are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            hold_q <= HOLD_CYCLES;
    else if (hold_q != '0)   hold_q <= hold_q - 4'd1;
  end

  // FIFO storage: {eop, data} per entry.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; pointers alone define validity,
    // and leaving it unreset lets it map onto RAM.
    if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {push_eop, rd_data};
  end

  // FIFO pointers, one extra bit to tell full from empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  assign head     = mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign out_vld  = !empty;
  assign out_data = head[SRAM_DATA_WIDTH-1:0];
  assign out_eop  = out_vld & head[SRAM_DATA_WIDTH];
  assign busy     = (state_q != IDLE) | out_vld;

  // The credit rule keeps a write into a full FIFO unreachable.
  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!reset_n) !(push && full));

endmodule

// File: tb/tb_sram_rd_burst_fetch.sv
// Bench for sram_rd_burst_fetch: an arbiter/SRAM model that acks requests and
// returns data a fixed latency later, a scoreboard of expected output words
// filled when commands are issued, and a monitor that pops and compares.
module tb_sram_rd_burst_fetch;

  localparam int AW = 19, DW = 36, LW = 8, FAW = 4;
  localparam int DEPTH = 2 ** FAW;
  localparam int LAT = 4;

  logic          clk, reset_n;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          rd_req, rd_ack, rd_vld;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data, out_data;
  logic          out_vld, out_eop, out_rdy, busy;

  sram_rd_burst_fetch #(
    .SRAM_ADDR_WIDTH(AW), .SRAM_DATA_WIDTH(DW), .LEN_WIDTH(LW), .FIFO_AW(FAW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_vld(rd_vld), .rd_data(rd_data),
    .out_vld(out_vld), .out_data(out_data), .out_eop(out_eop), .out_rdy(out_rdy),
    .busy(busy)
  );

  typedef struct { logic [DW-1:0] data; logic eop; } exp_t;
  typedef struct { int due; logic [DW-1:0] data; } ret_t;

  exp_t          exp_q[$];
  ret_t          ret_q[$];
  logic [AW-1:0] addr_log[$];

  int checks = 0, errors = 0;
  int ack_cnt = 0, pops = 0, eop_cnt = 0, req_cnt = 0, peak = 0, cyc = 0;
  bit ack_block, ack_random, rdy_rand, rdy_fixed;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return {~a[16:0], a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_rd_req"},    rd_req,    0);
    check({tag, "_out_vld"},   out_vld,   0);
    check({tag, "_out_eop"},   out_eop,   0);
    check({tag, "_busy"},      busy,      0);
  endtask

  // Offer a command until accepted; expected output words are queued then.
  task automatic issue_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l);
    int n;
    n = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 1000);
    check("cmd_accepted", cmd_ready, 1);
    for (int i = 0; i < int'(l); i++)
      exp_q.push_back('{data: data_of(a + AW'(i)), eop: (i == int'(l) - 1)});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin @(negedge clk); n++; end
    check({name, "_idle_busy"}, busy, 0);
    check({name, "_idle_pending"}, exp_q.size(), 0);
  endtask

  task automatic check_addrs(input string name, input int l0, input logic [AW-1:0] base, input int len);
    logic [AW-1:0] ea;
    check({name, "_addr_count"}, addr_log.size() - l0, len);
    for (int i = 0; i < len; i++) begin
      ea = base + AW'(i);
      check({name, "_addr"}, addr_log[l0 + i], ea);
    end
  endtask

  // Arbiter + SRAM: an address requested in one cycle may be acked in the
  // next; its data returns LAT cycles after the ack.
  initial begin : arbiter
    logic          req_prev;
    logic [AW-1:0] addr_prev;
    ret_t          r;
    req_prev = 1'b0; addr_prev = '0;
    rd_ack = 1'b0; rd_vld = 1'b0; rd_data = '0;
    forever begin
      @(posedge clk); #2;
      cyc++;
      rd_vld = 1'b0;
      if (ret_q.size() != 0 && ret_q[0].due <= cyc) begin
        r = ret_q.pop_front();
        rd_vld = 1'b1; rd_data = r.data;
      end
      rd_ack = req_prev && !ack_block &&
               (!ack_random || ($urandom_range(0, 99) < 70));
      if (rd_ack) begin
        ret_q.push_back('{due: cyc + LAT, data: data_of(addr_prev)});
        addr_log.push_back(addr_prev);
        ack_cnt++;
      end
      @(negedge clk);
      req_prev = rd_req; addr_prev = rd_addr;
    end
  end

  // Consumer ready: fixed level or random.
  initial begin : rdy_drv
    out_rdy = 1'b0;
    forever begin
      @(posedge clk); #2;
      out_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  // Monitor: compare every consumed word with the scoreboard head.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (rd_req) req_cnt++;
        if (ack_cnt - pops > peak) peak = ack_cnt - pops;
        if (out_vld && out_rdy) begin
          pops++;
          if (out_eop) eop_cnt++;
          if (exp_q.size() == 0) begin
            check("out_spurious_vld", out_vld, 0);
          end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_eop", out_eop, e.eop);
          end
        end
      end
    end
  end

  initial begin : main
    int a0, p0, e0, r0, l0, n, sum;
    logic [AW-1:0] base;
    logic [LW-1:0] len;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    ack_block = 1'b0; ack_random = 1'b0; rdy_rand = 1'b0; rdy_fixed = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("in_reset");
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset");
    repeat (10) @(posedge clk);

    // Single burst.
    a0 = ack_cnt; p0 = pops; e0 = eop_cnt; l0 = addr_log.size();
    issue_cmd(19'h00100, 8'd4);
    wait_idle("s1", 200);
    check("s1_acks", ack_cnt - a0, 4);
    check("s1_words", pops - p0, 4);
    check("s1_eops", eop_cnt - e0, 1);
    check_addrs("s1", l0, 19'h00100, 4);
    check("s1_cmd_ready", cmd_ready, 1);

    // Credit backpressure with a stalled consumer.
    rdy_fixed = 1'b0; peak = 0;
    base = AW'($urandom); a0 = ack_cnt; p0 = pops;
    issue_cmd(base, 8'd40);
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("s2_acks_stalled", ack_cnt - a0, 16);
    check("s2_rd_req_low", rd_req, 0);
    check("s2_no_words_out", pops - p0, 0);
    check("s2_out_vld", out_vld, 1);
    @(posedge clk); #1 rdy_fixed = 1'b1;
    wait_idle("s2", 400);
    check("s2_acks", ack_cnt - a0, 40);
    check("s2_words", pops - p0, 40);
    check("s2_peak", peak, DEPTH);

    // Arbiter withdraws acks for 3 cycles mid-burst.
    base = AW'($urandom); a0 = ack_cnt; l0 = addr_log.size();
    issue_cmd(base, 8'd12);
    n = 0;
    while (ack_cnt - a0 < 4 && n < 100) begin @(posedge clk); n++; end
    #1 ack_block = 1'b1;
    repeat (3) @(posedge clk);
    #1 ack_block = 1'b0;
    wait_idle("s3", 300);
    check("s3_acks", ack_cnt - a0, 12);
    check_addrs("s3", l0, base, 12);

    // Address wrap, then a zero-length command.
    l0 = addr_log.size(); e0 = eop_cnt;
    issue_cmd(19'h7FFFE, 8'd4);
    wait_idle("s4", 200);
    check_addrs("s4", l0, 19'h7FFFE, 4);
    check("s4_eops", eop_cnt - e0, 1);
    r0 = req_cnt; p0 = pops;
    issue_cmd(19'h00200, 8'd0);
    repeat (12) @(negedge clk);
    check("s4_zero_no_req", req_cnt - r0, 0);
    check("s4_zero_no_words", pops - p0, 0);
    check("s4_zero_cmd_ready", cmd_ready, 1);
    check("s4_zero_busy", busy, 0);

    // Back-to-back: second command while 3 words of the first are queued.
    rdy_fixed = 1'b0; p0 = pops; e0 = eop_cnt;
    issue_cmd(AW'($urandom), 8'd6);
    n = 0;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 200);
    check("s5_first_done", cmd_ready, 1);
    @(posedge clk); #1 rdy_fixed = 1'b1;
    repeat (3) @(posedge clk);
    #1 rdy_fixed = 1'b0;
    @(negedge clk);
    check("s5_three_popped", pops - p0, 3);
    check("s5_three_left", out_vld, 1);
    issue_cmd(AW'($urandom), 8'd2);
    @(posedge clk); #1 rdy_fixed = 1'b1;
    wait_idle("s5", 200);
    check("s5_words", pops - p0, 8);
    check("s5_eops", eop_cnt - e0, 2);

    // Randomized bursts with random acks and consumer stalls.
    ack_random = 1'b1; rdy_rand = 1'b1; peak = 0; a0 = ack_cnt; sum = 0;
    for (int k = 0; k < 10; k++) begin
      len  = LW'($urandom_range(1, 40));
      base = AW'($urandom);
      issue_cmd(base, len);
      sum += int'(len);
    end
    wait_idle("rand", 5000);
    check("rand_acks", ack_cnt - a0, sum);
    check("rand_peak_within_depth", peak <= DEPTH, 1);
    ack_random = 1'b0; rdy_rand = 1'b0; rdy_fixed = 1'b1;

    // Reset pulsed mid-burst, after 5 of 10 acks.
    a0 = ack_cnt;
    issue_cmd(AW'($urandom), 8'd10);
    n = 0;
    while (ack_cnt - a0 < 5 && n < 100) begin @(posedge clk); n++; end
    #1 reset_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_outputs("s6_in_reset");
    @(posedge clk);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("s6_after_reset");
    p0 = pops;
    repeat (10) @(negedge clk);
    check("s6_late_data_ignored", pops - p0, 0);
    check("s6_busy", busy, 0);
    a0 = ack_cnt; p0 = pops; e0 = eop_cnt;
    issue_cmd(AW'($urandom), 8'd5);
    wait_idle("s6", 200);
    check("s6_acks", ack_cnt - a0, 5);
    check("s6_words", pops - p0, 5);
    check("s6_eops", eop_cnt - e0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_rd_burst_fetch.md
SRAM_RD_BURST_FETCH -- requirements
Module: sram_rd_burst_fetch

Interface
REQ-001 Parameter SRAM_ADDR_WIDTH, default 19, SHALL set the SRAM word address width.
REQ-002 Parameter SRAM_DATA_WIDTH, default 36, SHALL set the SRAM word data width.
REQ-003 Parameter LEN_WIDTH, default 8, SHALL set the burst length field width, in words.
REQ-004 Parameter FIFO_AW, default 4, SHALL set the return FIFO depth to DEPTH = 2**FIFO_AW words.
REQ-005 The block SHALL use one clock, clk, and an asynchronous active-low reset, reset_n.
REQ-006 Ports SHALL be, in this order (name, direction, width, meaning):
- clk, in, 1, clock.
- reset_n, in, 1, async active-low reset.
- cmd_valid, in, 1, burst command offered.
- cmd_addr, in, SRAM_ADDR_WIDTH, first word address.
- cmd_len, in, LEN_WIDTH, number of words.
- cmd_ready, out, 1, command accepted when high together with cmd_valid.
- rd_req, out, 1, read request to the arbiter read port.
- rd_addr, out, SRAM_ADDR_WIDTH, read address.
- rd_ack, in, 1, the address presented one cycle earlier was consumed.
- rd_vld, in, 1, rd_data holds a returned word.
- rd_data, in, SRAM_DATA_WIDTH, returned word.
- out_vld, out, 1, output word available.
- out_data, out, SRAM_DATA_WIDTH, output word.
- out_eop, out, 1, last word of a burst.
- out_rdy, in, 1, consumer takes the word.
- busy, out, 1, command in progress or FIFO not empty.

Function
REQ-007 The state machine SHALL have three states, IDLE, ISSUE and DRAIN.
REQ-008 cmd_ready SHALL be 1 only in IDLE; on cmd_valid&cmd_ready the block SHALL latch addr/len and clear the acked and returned counters.
REQ-009 A command with cmd_len=0 SHALL be accepted and discarded: the block stays in IDLE, issues no reads and produces no output.
REQ-010 A command with cmd_len!=0 SHALL move the block to ISSUE on the next cycle.
REQ-011 acked SHALL increment once per cycle in which rd_ack=1 while the block is in ISSUE.
REQ-012 rd_addr SHALL equal base + acked + rd_ack (combinational, modulo 2**SRAM_ADDR_WIDTH), so the arbiter always sees the next unconsumed address, including in the cycle an ack arrives.
REQ-013 Define inflight = acked - returned and occ = FIFO occupancy.
REQ-014 rd_req SHALL be combinational and high only in ISSUE, and only when (len - acked - rd_ack) > 0 and (occ + inflight + rd_ack + 1) <= DEPTH.
REQ-015 The block SHALL NOT rely on the arbiter honouring rd_req low in any cycle other than the current one.
REQ-016 When acked reaches len, the block SHALL go ISSUE->DRAIN; rd_req SHALL be 0 in DRAIN.
REQ-017 Every rd_vld=1 cycle SHALL write {eop, rd_data} to the FIFO and increment returned, with eop = (returned == len-1).
REQ-018 rd_vld SHALL be accepted in any state.
REQ-019 The block SHALL go DRAIN->IDLE in the cycle after returned reaches len; FIFO words still queued SHALL continue to drain.
REQ-020 A new command MAY be accepted while the FIFO holds words of the previous burst; those words SHALL keep their order and their eop flags.
REQ-021 The FIFO SHALL be first-word-fall-through: out_vld = !empty, and out_data/out_eop SHALL show the head entry.
REQ-022 A pop SHALL occur on out_vld&out_rdy.
REQ-023 A simultaneous push and pop SHALL leave occ unchanged.
REQ-024 The FIFO pointers SHALL be FIFO_AW+1 bits wide and wrap modulo 2**(FIFO_AW+1); full SHALL be flagged at occ == DEPTH.
REQ-025 The credit rule of REQ-014 SHALL make a push while full unreachable; in simulation, a push while full SHALL trigger an assertion.
REQ-026 busy SHALL equal (state != IDLE) | out_vld.
REQ-027 Counters acked and returned SHALL be LEN_WIDTH+1 bits wide, so len up to 2**LEN_WIDTH-1 is exact.

Reset
REQ-028 While reset_n=0, all registers SHALL clear asynchronously: state=IDLE, counters=0, FIFO empty.
REQ-029 Outputs during and right after reset SHALL be cmd_ready=1, rd_req=0, out_vld=0, out_eop=0, busy=0.
REQ-030 Reset asserted mid-burst SHALL discard all pending and inflight data.
REQ-031 rd_vld arriving after reset release for reads issued before reset SHALL be ignored for 8 cycles after reset_n rises.

Verification
REQ-032 Scenario, single burst: cmd addr=0x100, len=4; arbiter acks every cycle; 4-cycle data latency; out_rdy=1 -> rd_addr sequence 0x100..0x103, exactly 4 acks consumed, 4 out words in order, out_eop on the 4th only, block back in IDLE.
REQ-033 Scenario, credit backpressure: len=40, out_rdy=0 -> rd_req drops once occ+inflight reaches 16; exactly 16 words stored, no assertion fires; after out_rdy=1 the remaining 24 words follow, 40 words total.
REQ-034 Scenario, preempt: arbiter drops ack for 3 cycles mid-burst (port switched) then resumes -> no address skipped or repeated; returned data matches the addresses sent.
REQ-035 Scenario, wrap and zero length: cmd addr=0x7FFFE, len=4 -> addresses 0x7FFFE, 0x7FFFF, 0x00000, 0x00001; a cmd with len=0 -> no rd_req, no output, cmd_ready stays 1.
REQ-036 Scenario, back-to-back: second cmd (len=2) accepted while 3 words of the first remain in the FIFO -> output order preserved, two out_eop pulses at the correct words.
REQ-037 Scenario, reset mid-burst: reset_n pulsed low for 2 cycles after 5 of 10 acks -> outputs at their reset values, late rd_vld ignored, a new burst completes correctly.
